csr_unit: RTL and testbench



---
 rtl/csr_pkg.sv | 37 +++
 rtl/csr_counter.sv | 29 ++
 rtl/csr_unit.sv | 167 ++++++++++++++++
 tb/tb_csr_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, op encoding,
// mstatus field positions and the address-decode helper.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [1:0] MSTATUS_MPP_M = 2'b11;

  function automatic logic csr_is_implemented(input logic [11:0] addr);
    logic hit;
    case (addr)
      CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
      CSR_MCAUSE, CSR_MCYCLE, CSR_MINSTRET: hit = 1'b1;
      default:                              hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/csr_counter.sv
// Free-running wrap-around counter with a load port; a load takes precedence
// over the increment in the same cycle.
module csr_counter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            load,
  input  logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] value
);

  logic [XLEN-1:0] count_r;

  // Count register: load wins, otherwise step by one when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {XLEN{1'b0}};
    end else if (load) begin
      count_r <= load_data;
    end else if (inc) begin
      count_r <= count_r + {{(XLEN-1){1'b0}}, 1'b1};
    end
  end

  assign value = count_r;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: CSRRW/RS/RC with legality checks, trap entry and
// MRET sequencing on mstatus, vectored trap target, mcycle/minstret.
module csr_unit
  import csr_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] MTVEC_RESET  = {XLEN{1'b0}},
  parameter int              HAS_COUNTERS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] trap_vector,
  input  logic            mret_valid,
  output logic [XLEN-1:0] mepc_out,
  input  logic            instret_inc,
  output logic            mstatus_mie
);

  csr_op_e         op_s;
  logic            mie_r;
  logic            mpie_r;
  logic [XLEN-1:0] mtvec_r;
  logic [XLEN-1:0] mscratch_r;
  logic [XLEN-1:0] mepc_r;
  logic [XLEN-1:0] mcause_r;
  logic [XLEN-1:0] mcycle_s;
  logic [XLEN-1:0] minstret_s;
  logic [XLEN-1:0] mstatus_s;
  logic [XLEN-1:0] rdata_s;
  logic [XLEN-1:0] new_s;
  logic [XLEN-1:0] vec_base_s;
  logic            implemented_s;
  logic            read_only_s;
  logic            access_bad_s;
  logic            wr_en_s;
  logic            mcycle_load_s;
  logic            minstret_load_s;
  logic            unused_s;

  assign op_s = csr_op_e'(csr_op);

  // mstatus view: two storage bits plus the hardwired machine-mode MPP.
  always_comb begin
    mstatus_s                                = {XLEN{1'b0}};
    mstatus_s[MSTATUS_MIE]                   = mie_r;
    mstatus_s[MSTATUS_MPIE]                  = mpie_r;
    mstatus_s[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = MSTATUS_MPP_M;
  end

  // Read mux; unimplemented addresses read as zero.
  always_comb begin
    rdata_s = {XLEN{1'b0}};
    case (csr_addr)
      CSR_MSTATUS:  rdata_s = mstatus_s;
      CSR_MTVEC:    rdata_s = mtvec_r;
      CSR_MSCRATCH: rdata_s = mscratch_r;
      CSR_MEPC:     rdata_s = mepc_r;
      CSR_MCAUSE:   rdata_s = mcause_r;
      CSR_MCYCLE:   rdata_s = mcycle_s;
      CSR_MINSTRET: rdata_s = minstret_s;
      default:      rdata_s = {XLEN{1'b0}};
    endcase
  end

  // Read-modify-write result from the old value and the operand.
  always_comb begin
    new_s = rdata_s;
    case (op_s)
      CSR_OP_RW: new_s = csr_wdata;
      CSR_OP_RS: new_s = rdata_s | csr_wdata;
      CSR_OP_RC: new_s = rdata_s & ~csr_wdata;
      default:   new_s = rdata_s;
    endcase
  end

  // Every op is a write, so the read-only space rejects all of them.
  assign implemented_s = csr_is_implemented(csr_addr);
  assign read_only_s   = (csr_addr[11:10] == 2'b11);
  assign access_bad_s  = (op_s != CSR_OP_NONE) && (!implemented_s || read_only_s);
  assign csr_illegal   = access_bad_s && !trap_valid && !mret_valid;
  assign wr_en_s       = (op_s != CSR_OP_NONE) && !access_bad_s && !trap_valid && !mret_valid;

  assign mcycle_load_s   = wr_en_s && (csr_addr == CSR_MCYCLE);
  assign minstret_load_s = wr_en_s && (csr_addr == CSR_MINSTRET);

  // Architectural state: trap beats MRET beats a software write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_r      <= 1'b0;
      mpie_r     <= 1'b0;
      mtvec_r    <= MTVEC_RESET;
      mscratch_r <= {XLEN{1'b0}};
      mepc_r     <= {XLEN{1'b0}};
      mcause_r   <= {XLEN{1'b0}};
    end else if (trap_valid) begin
      mepc_r   <= {trap_pc[XLEN-1:2], 2'b00};
      mcause_r <= trap_cause;
      mpie_r   <= mie_r;
      mie_r    <= 1'b0;
    end else if (mret_valid) begin
      mie_r  <= mpie_r;
      mpie_r <= 1'b1;
    end else if (wr_en_s) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie_r  <= new_s[MSTATUS_MIE];
          mpie_r <= new_s[MSTATUS_MPIE];
        end
        CSR_MTVEC:    mtvec_r    <= {new_s[XLEN-1:2], 1'b0, new_s[0]};
        CSR_MSCRATCH: mscratch_r <= new_s;
        CSR_MEPC:     mepc_r     <= {new_s[XLEN-1:2], 2'b00};
        CSR_MCAUSE:   mcause_r   <= new_s;
        default:      mtvec_r    <= mtvec_r;
      endcase
    end
  end

  generate
    if (HAS_COUNTERS != 0) begin : g_counters
      csr_counter #(.XLEN(XLEN)) u_mcycle (
        .clk       (clk),
        .rst       (rst),
        .inc       (1'b1),
        .load      (mcycle_load_s),
        .load_data (new_s),
        .value     (mcycle_s)
      );
      csr_counter #(.XLEN(XLEN)) u_minstret (
        .clk       (clk),
        .rst       (rst),
        .inc       (instret_inc),
        .load      (minstret_load_s),
        .load_data (new_s),
        .value     (minstret_s)
      );
    end else begin : g_no_counters
      logic unused_cnt_s;
      assign mcycle_s     = {XLEN{1'b0}};
      assign minstret_s   = {XLEN{1'b0}};
      assign unused_cnt_s = ^{instret_inc, mcycle_load_s, minstret_load_s};
    end
  endgenerate

  // Vectored interrupts offset the base by 4*cause, wrapping at XLEN.
  always_comb begin
    vec_base_s = {mtvec_r[XLEN-1:2], 2'b00};
    if (mtvec_r[0] && trap_cause[XLEN-1]) begin
      trap_vector = vec_base_s + {trap_cause[XLEN-3:0], 2'b00};
    end else begin
      trap_vector = vec_base_s;
    end
  end

  assign csr_rdata   = rdata_s;
  assign mepc_out    = mepc_r;
  assign mstatus_mie = mie_r;
  assign unused_s    = ^trap_pc[1:0];

endmodule

// File: tb/tb_csr_unit.sv
// Scoreboarded bench for csr_unit: directed plan plus random traffic checked
// against an address-keyed register model.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] csr_addr = 12'h000;
  logic [1:0]  csr_op = 2'b00;
  logic [63:0] csr_wdata = 64'h0;
  logic [63:0] csr_rdata;
  logic        csr_illegal;
  logic        trap_valid = 1'b0;
  logic [63:0] trap_cause = 64'h0;
  logic [63:0] trap_pc = 64'h0;
  logic [63:0] trap_vector;
  logic        mret_valid = 1'b0;
  logic [63:0] mepc_out;
  logic        instret_inc = 1'b0;
  logic        mstatus_mie;

  csr_unit dut (
    .clk         (clk),
    .rst         (rst),
    .csr_addr    (csr_addr),
    .csr_op      (csr_op),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .csr_illegal (csr_illegal),
    .trap_valid  (trap_valid),
    .trap_cause  (trap_cause),
    .trap_pc     (trap_pc),
    .trap_vector (trap_vector),
    .mret_valid  (mret_valid),
    .mepc_out    (mepc_out),
    .instret_inc (instret_inc),
    .mstatus_mie (mstatus_mie)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          seq;
    logic [63:0] rd;
    logic        ill;
    logic [63:0] vec;
    logic [63:0] mepc;
    logic        mie;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   seq_no = 0;

  // Reference model: each CSR's full architectural read value by address.
  logic [63:0] mm [logic [11:0]];

  function automatic logic [63:0] m_read(input logic [11:0] a);
    return mm.exists(a) ? mm[a] : 64'h0;
  endfunction

  function automatic logic m_legal(input logic [11:0] a);
    return mm.exists(a) && (a[11:10] != 2'b11);
  endfunction

  task automatic model_reset();
    mm.delete();
    mm[12'h300] = 64'h1800;
    mm[12'h305] = 64'h0;
    mm[12'h340] = 64'h0;
    mm[12'h341] = 64'h0;
    mm[12'h342] = 64'h0;
    mm[12'hB00] = 64'h0;
    mm[12'hB02] = 64'h0;
  endtask

  task automatic model_step(input logic [11:0] a, input logic [1:0] op, input logic [63:0] wd,
                            input logic tv, input logic [63:0] tc, input logic [63:0] tp,
                            input logic mr, input logic inc);
    logic [63:0] nx [logic [11:0]];
    logic [63:0] old, nv;
    nx = mm;
    nx[12'hB00] = mm[12'hB00] + 64'd1;
    nx[12'hB02] = mm[12'hB02] + (inc ? 64'd1 : 64'd0);
    if (tv) begin
      nx[12'h341] = tp & ~64'h3;
      nx[12'h342] = tc;
      nx[12'h300] = 64'h1800 | (mm[12'h300][3] ? 64'h80 : 64'h0);
    end else if (mr) begin
      nx[12'h300] = 64'h1880 | (mm[12'h300][7] ? 64'h8 : 64'h0);
    end else if (op != 2'b00 && m_legal(a)) begin
      old = m_read(a);
      nv  = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
      case (a)
        12'h300: nx[a] = 64'h1800 | (nv & 64'h88);
        12'h305: nx[a] = nv & ~64'h2;
        12'h341: nx[a] = nv & ~64'h3;
        default: nx[a] = nv;
      endcase
    end
    mm = nx;
  endtask

  // One cycle: drive, predict visible outputs, queue them, advance the model.
  task automatic cyc(input logic [11:0] a, input logic [1:0] op, input logic [63:0] wd,
                     input logic tv, input logic [63:0] tc, input logic [63:0] tp,
                     input logic mr, input logic inc,
                     input logic lr_en, input logic [63:0] lr,
                     input logic lv_en, input logic [63:0] lv);
    exp_t e;
    logic [63:0] base;
    csr_addr = a; csr_op = op; csr_wdata = wd;
    trap_valid = tv; trap_cause = tc; trap_pc = tp;
    mret_valid = mr; instret_inc = inc;
    base   = mm[12'h305] & ~64'h3;
    e.seq  = seq_no++;
    e.rd   = lr_en ? lr : m_read(a);
    e.ill  = (op != 2'b00) && !m_legal(a) && !tv && !mr;
    e.vec  = lv_en ? lv : ((mm[12'h305][0] && tc[63]) ? base + (tc << 2) : base);
    e.mepc = mm[12'h341];
    e.mie  = mm[12'h300][3];
    q.push_back(e);
    model_step(a, op, wd, tv, tc, tp, mr, inc);
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [63:0] v);
    cyc(a, 2'b00, 64'h0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1, v, 1'b0, 64'h0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [63:0] wd);
    cyc(a, op, wd, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
  endtask

  task automatic idle_inputs();
    csr_addr = 12'h000; csr_op = 2'b00; csr_wdata = 64'h0;
    trap_valid = 1'b0; trap_cause = 64'h0; trap_pc = 64'h0;
    mret_valid = 1'b0; instret_inc = 1'b0;
  endtask

  // Reset with optional pending trap/MRET/write, which reset must override.
  task automatic do_reset(input logic pending);
    if (pending) begin
      csr_addr = 12'h340; csr_op = 2'b01; csr_wdata = 64'hDEAD;
      trap_valid = 1'b1; trap_cause = 64'h5; trap_pc = 64'h4444;
      mret_valid = 1'b1; instret_inc = 1'b1;
    end else begin
      idle_inputs();
    end
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk(input int seq, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s seq=%0d actual=%h required=%h", name, seq, act, req);
    end
  endtask

  // Monitor: outputs settle half a cycle after each drive.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk(e.seq, "rdata", csr_rdata, e.rd);
        chk(e.seq, "illegal", {63'h0, csr_illegal}, {63'h0, e.ill});
        chk(e.seq, "trap_vector", trap_vector, e.vec);
        chk(e.seq, "mepc_out", mepc_out, e.mepc);
        chk(e.seq, "mstatus_mie", {63'h0, mstatus_mie}, {63'h0, e.mie});
      end
    end
  end

  logic [11:0] addr_tbl [0:8] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                                  12'hB00, 12'hB02, 12'h7C0, 12'hF14};

  initial begin
    logic [11:0] a;
    logic [63:0] tc;
    @(posedge clk);
    #1;
    do_reset(1'b0);

    rd(12'h300, 64'h1800);
    rd(12'h305, 64'h0);
    wr(12'h300, 2'b10, 64'h8);
    rd(12'h300, 64'h1808);
    wr(12'h300, 2'b11, 64'h8);
    rd(12'h300, 64'h1800);
    wr(12'h300, 2'b10, 64'h8);
    cyc(12'h300, 2'b00, 64'h0, 1'b1, 64'hB, 64'h80000042, 1'b0, 1'b0, 1'b1, 64'h1808, 1'b0, 64'h0);
    rd(12'h341, 64'h80000040);
    rd(12'h342, 64'hB);
    rd(12'h300, 64'h1880);
    cyc(12'h300, 2'b00, 64'h0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 1'b1, 64'h1880, 1'b0, 64'h0);
    rd(12'h300, 64'h1888);

    wr(12'h305, 2'b01, 64'h80000101);
    cyc(12'h305, 2'b00, 64'h0, 1'b0, 64'h8000000000000007, 64'h0, 1'b0, 1'b0,
        1'b1, 64'h80000101, 1'b1, 64'h8000011C);
    cyc(12'h305, 2'b00, 64'h0, 1'b0, 64'h2, 64'h0, 1'b0, 1'b0,
        1'b1, 64'h80000101, 1'b1, 64'h80000100);

    cyc(12'h341, 2'b01, 64'h1234, 1'b1, 64'h3, 64'h100, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    rd(12'h341, 64'h100);

    wr(12'hB00, 2'b01, 64'hFFFFFFFFFFFFFFFF);
    rd(12'hB00, 64'hFFFFFFFFFFFFFFFF);
    rd(12'hB00, 64'h0);

    wr(12'h7C0, 2'b01, 64'h55);
    wr(12'hF14, 2'b10, 64'hFF);
    for (int i = 0; i < 7; i++) begin
      a = addr_tbl[i];
      cyc(a, 2'b00, 64'h0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    end

    for (int i = 0; i < 500; i++) begin
      a  = addr_tbl[$urandom_range(0, 8)];
      tc = {$urandom, $urandom};
      cyc(a, 2'($urandom_range(0, 3)), {$urandom, $urandom},
          ($urandom_range(0, 7) == 0), tc, {$urandom, $urandom},
          ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
          1'b0, 64'h0, 1'b0, 64'h0);
    end

    do_reset(1'b1);
    rd(12'h300, 64'h1800);
    rd(12'h340, 64'h0);
    rd(12'h341, 64'h0);
    rd(12'h305, 64'h0);
    rd(12'hB02, 64'h0);

    idle_inputs();
    for (int i = 0; i < 4 && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d pending required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
